// File: rtl/dummy_memory.sv
// Multi-port word-addressed TCDM memory model for block-level benches: byte storage,
// per-port pseudo-random grant stalls and per-port read/write access counters.
module dummy_memory #(
  parameter int          MP          = 1,
  parameter int          MEMORY_SIZE = 196608,
  parameter logic [31:0] BASE_ADDR   = 32'h1c000000,
  parameter int          PROB_STALL  = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clk_delayed_i,
  input  logic                 randomize_i,
  input  logic                 enable_i,
  input  logic                 stallable_i,
  input  logic [MP-1:0]        tcdm_req_i,
  input  logic [MP-1:0][31:0]  tcdm_add_i,
  input  logic [MP-1:0]        tcdm_wen_i,
  input  logic [MP-1:0][3:0]   tcdm_be_i,
  input  logic [MP-1:0][31:0]  tcdm_data_i,
  output logic [MP-1:0]        tcdm_gnt_o,
  output logic [MP-1:0][31:0]  tcdm_r_data_o,
  output logic [MP-1:0]        tcdm_r_valid_o,
  output logic [MP-1:0][31:0]  cnt_rd,
  output logic [MP-1:0][31:0]  cnt_wr
);

  localparam int         IW        = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
  localparam logic [7:0] STALL_THR = 8'((PROB_STALL * 128) / 100);

  logic [7:0] memory [0:MEMORY_SIZE-1];

  logic [MP-1:0][7:0]    lfsr_q, lfsr_d;
  logic [MP-1:0]         stall, gnt;
  logic [MP-1:0]         r_valid_q;
  logic [MP-1:0][31:0]   r_data_q, r_word;
  logic [MP-1:0][31:0]   cnt_rd_q, cnt_wr_q;
  logic [MP-1:0][IW-1:0] idx;

  logic unused_clk_delayed;
  assign unused_clk_delayed = clk_delayed_i;

  // Word-aligned offset from BASE_ADDR, wrapped into the storage.
  function automatic logic [IW-1:0] index_f(input logic [31:0] add);
    return IW'(((add - BASE_ADDR) & 32'hFFFF_FFFC) % MEMORY_SIZE);
  endfunction

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1.
  function automatic logic [7:0] lfsr_step_f(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  always_comb begin
    lfsr_d = lfsr_q;
    stall  = '0;
    gnt    = '0;
    idx    = '0;
    r_word = '0;
    for (int i = 0; i < MP; i++) begin
      lfsr_d[i] = lfsr_step_f(lfsr_q[i]);
      stall[i]  = stallable_i && ({1'b0, lfsr_q[i][6:0]} < STALL_THR);
      gnt[i]    = tcdm_req_i[i] && enable_i && !stall[i];
      idx[i]    = index_f(tcdm_add_i[i]);
      r_word[i] = {memory[idx[i] + IW'(3)], memory[idx[i] + IW'(2)],
                   memory[idx[i] + IW'(1)], memory[idx[i]]};
    end
  end

  // Later ports overwrite earlier ones per byte; reads see pre-edge contents.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MP; i++) begin
      if (gnt[i] && !tcdm_wen_i[i]) begin
        for (int k = 0; k < 4; k++) begin
          if (tcdm_be_i[i][k]) begin
            memory[idx[i] + IW'(k)] <= tcdm_data_i[i][8*k +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MP; i++) begin
      if (gnt[i]) begin
        r_data_q[i] <= tcdm_wen_i[i] ? r_word[i] : 32'h0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < MP; i++) begin
        lfsr_q[i] <= 8'(i + 1);
      end
      r_valid_q <= '0;
      cnt_rd_q  <= '0;
      cnt_wr_q  <= '0;
    end else begin
      lfsr_q    <= lfsr_d;
      r_valid_q <= gnt;
      for (int i = 0; i < MP; i++) begin
        if (gnt[i] && tcdm_wen_i[i]) begin
          cnt_rd_q[i] <= cnt_rd_q[i] + 32'd1;
        end
        if (gnt[i] && !tcdm_wen_i[i]) begin
          cnt_wr_q[i] <= cnt_wr_q[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    tcdm_r_data_o = '0;
    for (int i = 0; i < MP; i++) begin
      if (r_valid_q[i]) begin
        tcdm_r_data_o[i] = r_data_q[i];
      end else if (randomize_i) begin
        tcdm_r_data_o[i] = {4{lfsr_q[i]}};
      end
    end
  end

  assign tcdm_gnt_o     = gnt;
  assign tcdm_r_valid_o = r_valid_q;
  assign cnt_rd         = cnt_rd_q;
  assign cnt_wr         = cnt_wr_q;

endmodule

// File: tb/tb_dummy_memory.sv
// Directed bench for dummy_memory: a 2-port main instance plus two 1-port
// instances configured with 100% and 50% stall probability.
module tb_dummy_memory;

  localparam logic [31:0] BASE = 32'h1c000000;
  localparam int          MSZ  = 196608;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rnd, en, stl;
  logic [1:0]       req, wen, gnt, rvalid;
  logic [1:0][31:0] add, wdata, rdata, cnt_rd, cnt_wr;
  logic [1:0][3:0]  be;

  logic        s1_req, s1_stl, s1_gnt, s1_rvalid;
  logic [31:0] s1_rdata, s1_cnt_rd, s1_cnt_wr;
  logic        s5_req, s5_stl, s5_gnt, s5_rvalid;
  logic [31:0] s5_rdata, s5_cnt_rd, s5_cnt_wr;

  int n_cmp = 0;
  int n_fail = 0;

  dummy_memory #(.MP(2), .MEMORY_SIZE(MSZ), .BASE_ADDR(BASE), .PROB_STALL(0)) u_dut (
    .clk_i(clk), .rst_i(rst), .clk_delayed_i(1'b0), .randomize_i(rnd), .enable_i(en),
    .stallable_i(stl), .tcdm_req_i(req), .tcdm_add_i(add), .tcdm_wen_i(wen),
    .tcdm_be_i(be), .tcdm_data_i(wdata), .tcdm_gnt_o(gnt), .tcdm_r_data_o(rdata),
    .tcdm_r_valid_o(rvalid), .cnt_rd(cnt_rd), .cnt_wr(cnt_wr));

  dummy_memory #(.MP(1), .MEMORY_SIZE(1024), .BASE_ADDR(BASE), .PROB_STALL(100)) u_s100 (
    .clk_i(clk), .rst_i(rst), .clk_delayed_i(1'b0), .randomize_i(1'b0), .enable_i(en),
    .stallable_i(s1_stl), .tcdm_req_i(s1_req), .tcdm_add_i(BASE), .tcdm_wen_i(1'b1),
    .tcdm_be_i(4'hF), .tcdm_data_i(32'h0), .tcdm_gnt_o(s1_gnt), .tcdm_r_data_o(s1_rdata),
    .tcdm_r_valid_o(s1_rvalid), .cnt_rd(s1_cnt_rd), .cnt_wr(s1_cnt_wr));

  dummy_memory #(.MP(1), .MEMORY_SIZE(1024), .BASE_ADDR(BASE), .PROB_STALL(50)) u_s50 (
    .clk_i(clk), .rst_i(rst), .clk_delayed_i(1'b0), .randomize_i(1'b0), .enable_i(en),
    .stallable_i(s5_stl), .tcdm_req_i(s5_req), .tcdm_add_i(BASE), .tcdm_wen_i(1'b1),
    .tcdm_be_i(4'hF), .tcdm_data_i(32'h0), .tcdm_gnt_o(s5_gnt), .tcdm_r_data_o(s5_rdata),
    .tcdm_r_valid_o(s5_rvalid), .cnt_rd(s5_cnt_rd), .cnt_wr(s5_cnt_wr));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    req   = '0;
    wen   = 2'b11;
    add   = '0;
    be    = '0;
    wdata = '0;
  endtask

  task automatic put(input int p, input logic w, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] d);
    req[p]   = 1'b1;
    wen[p]   = w;
    add[p]   = a;
    be[p]    = b;
    wdata[p] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    cyc();
    cyc();
    rst = 1'b0;
    n_cmp++;
    if (rvalid !== 2'b00) begin
      n_fail++; $display("FAIL reset_rvalid: got %b expected 00", rvalid);
    end
    n_cmp++;
    if (rdata !== 64'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata);
    end
    n_cmp++;
    if (cnt_rd !== 64'h0 || cnt_wr !== 64'h0) begin
      n_fail++; $display("FAIL reset_counters: got rd=%h wr=%h expected 0", cnt_rd, cnt_wr);
    end
  endtask

  task automatic test_stall();
    int g;
    g = 0;
    s1_req = 1'b1;
    s1_stl = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #3; if (s1_gnt) g++;
      cyc();
    end
    n_cmp++;
    if (g !== 0 || s1_cnt_rd !== 32'd0) begin
      n_fail++; $display("FAIL stall100_on: got grants=%0d cnt=%0d expected 0/0", g, s1_cnt_rd);
    end
    g = 0;
    s1_stl = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #3; if (s1_gnt) g++;
      cyc();
    end
    s1_req = 1'b0;
    n_cmp++;
    if (g !== 20 || s1_cnt_rd !== 32'd20) begin
      n_fail++; $display("FAIL stall100_off: got grants=%0d cnt=%0d expected 20/20", g, s1_cnt_rd);
    end
    g = 0;
    s5_req = 1'b1;
    s5_stl = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      #3; if (s5_gnt) g++;
      cyc();
    end
    s5_req = 1'b0;
    n_cmp++;
    if (g < 400 || g > 600) begin
      n_fail++; $display("FAIL stall50_ratio: got %0d grants expected 400..600", g);
    end
    n_cmp++;
    if (s5_cnt_rd !== 32'(g)) begin
      n_fail++; $display("FAIL stall50_cnt: got %0d expected %0d", s5_cnt_rd, g);
    end
  endtask

  task automatic test_write_read();
    put(0, 1'b0, BASE + 32'd4, 4'hF, 32'hDEADBEEF);
    #3;
    n_cmp++;
    if (gnt !== 2'b01) begin
      n_fail++; $display("FAIL wr_gnt: got %b expected 01", gnt);
    end
    cyc();
    idle_all();
    n_cmp++;
    if (rvalid !== 2'b01 || rdata[0] !== 32'h0) begin
      n_fail++; $display("FAIL wr_resp: got valid=%b data=%h expected 01/0", rvalid, rdata[0]);
    end
    put(0, 1'b1, BASE + 32'd4, 4'h0, 32'h0);
    cyc();
    idle_all();
    n_cmp++;
    if (rvalid[0] !== 1'b1 || rdata[0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rd_resp: got valid=%b data=%h expected 1/deadbeef", rvalid[0], rdata[0]);
    end
    cyc();
    n_cmp++;
    if (rvalid !== 2'b00) begin
      n_fail++; $display("FAIL rd_single: got %b expected 00", rvalid);
    end
  endtask

  task automatic test_byte_enable();
    put(0, 1'b0, BASE + 32'd4, 4'b0101, 32'h11223344);
    cyc();
    put(0, 1'b1, BASE + 32'd6, 4'h0, 32'h0);
    cyc();
    idle_all();
    n_cmp++;
    if (rdata[0] !== 32'hDE22BE44) begin
      n_fail++; $display("FAIL byte_enable: got %h expected de22be44", rdata[0]);
    end
  endtask

  task automatic test_wrap();
    put(1, 1'b0, BASE + 32'(MSZ) + 32'd8, 4'hF, 32'hA5A50F0F);
    cyc();
    put(1, 1'b1, BASE + 32'd8, 4'h0, 32'h0);
    cyc();
    idle_all();
    n_cmp++;
    if (rdata[1] !== 32'hA5A50F0F) begin
      n_fail++; $display("FAIL addr_wrap: got %h expected a5a50f0f", rdata[1]);
    end
  endtask

  task automatic test_conflict();
    put(0, 1'b0, BASE + 32'd16, 4'hF, 32'h12345678);
    cyc();
    put(0, 1'b0, BASE + 32'd16, 4'hF, 32'hAAAAAAAA);
    put(1, 1'b0, BASE + 32'd16, 4'hF, 32'h55555555);
    #3;
    n_cmp++;
    if (gnt !== 2'b11) begin
      n_fail++; $display("FAIL conflict_gnt: got %b expected 11", gnt);
    end
    cyc();
    idle_all();
    put(0, 1'b0, BASE + 32'd16, 4'hF, 32'hCAFEF00D);
    put(1, 1'b1, BASE + 32'd16, 4'h0, 32'h0);
    cyc();
    idle_all();
    n_cmp++;
    if (rdata[1] !== 32'h55555555) begin
      n_fail++; $display("FAIL conflict_winner_or_old: got %h expected 55555555", rdata[1]);
    end
    put(1, 1'b1, BASE + 32'd16, 4'h0, 32'h0);
    cyc();
    idle_all();
    n_cmp++;
    if (rdata[1] !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL conflict_after: got %h expected cafef00d", rdata[1]);
    end
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 4; j++) begin
      put(0, 1'b0, BASE + 32'd64 + 32'(4 * j), 4'hF, 32'h10000000 + 32'(j));
      cyc();
    end
    for (int j = 0; j < 4; j++) begin
      put(0, 1'b1, BASE + 32'd64 + 32'(4 * j), 4'h0, 32'h0);
      cyc();
      n_cmp++;
      if (rvalid[0] !== 1'b1 || rdata[0] !== 32'h10000000 + 32'(j)) begin
        n_fail++; $display("FAIL b2b_read%0d: got valid=%b data=%h expected 1/%h",
                           j, rvalid[0], rdata[0], 32'h10000000 + 32'(j));
      end
    end
    idle_all();
  endtask

  task automatic test_enable_counters();
    int bad;
    bad = 0;
    rst = 1'b1;
    idle_all();
    cyc();
    rst = 1'b0;
    en  = 1'b0;
    put(0, 1'b1, BASE, 4'h0, 32'h0);
    put(1, 1'b0, BASE + 32'd200, 4'hF, 32'h0);
    for (int i = 0; i < 10; i++) begin
      #3; if (gnt !== 2'b00) bad++;
      cyc();
    end
    n_cmp++;
    if (bad !== 0 || cnt_rd !== 64'h0 || cnt_wr !== 64'h0) begin
      n_fail++; $display("FAIL enable_off: got %0d grant cycles rd=%h wr=%h expected 0", bad, cnt_rd, cnt_wr);
    end
    idle_all();
    en = 1'b1;
    for (int j = 0; j < 5; j++) begin
      put(1, 1'b1, BASE + 32'(4 * j), 4'h0, 32'h0);
      cyc();
    end
    for (int j = 0; j < 3; j++) begin
      put(1, 1'b0, BASE + 32'd128 + 32'(4 * j), 4'hF, 32'(j));
      cyc();
    end
    idle_all();
    n_cmp++;
    if (cnt_rd[1] !== 32'd5 || cnt_wr[1] !== 32'd3) begin
      n_fail++; $display("FAIL cnt_port1: got rd=%0d wr=%0d expected 5/3", cnt_rd[1], cnt_wr[1]);
    end
    n_cmp++;
    if (cnt_rd[0] !== 32'd0 || cnt_wr[0] !== 32'd0) begin
      n_fail++; $display("FAIL cnt_port0: got rd=%0d wr=%0d expected 0/0", cnt_rd[0], cnt_wr[0]);
    end
  endtask

  task automatic test_reset_midop();
    put(0, 1'b0, BASE + 32'd32, 4'hF, 32'h0BADC0DE);
    cyc();
    put(0, 1'b1, BASE + 32'd32, 4'h0, 32'h0);
    cyc();
    idle_all();
    n_cmp++;
    if (rvalid[0] !== 1'b1) begin
      n_fail++; $display("FAIL midop_pending: got %b expected 1", rvalid[0]);
    end
    rst = 1'b1;
    cyc();
    n_cmp++;
    if (rvalid !== 2'b00 || cnt_rd !== 64'h0 || cnt_wr !== 64'h0) begin
      n_fail++; $display("FAIL midop_reset: got valid=%b rd=%h wr=%h expected 0", rvalid, cnt_rd, cnt_wr);
    end
    rst = 1'b0;
    put(0, 1'b1, BASE + 32'd32, 4'h0, 32'h0);
    put(1, 1'b1, BASE + 32'd4, 4'h0, 32'h0);
    cyc();
    idle_all();
    n_cmp++;
    if (rdata[0] !== 32'h0BADC0DE || rdata[1] !== 32'hDE22BE44) begin
      n_fail++; $display("FAIL midop_mem_kept: got %h %h expected 0badc0de de22be44", rdata[0], rdata[1]);
    end
  endtask

  task automatic test_randomize();
    rst = 1'b1;
    idle_all();
    cyc();
    rst = 1'b0;
    rnd = 1'b1;
    #1;
    n_cmp++;
    if (rdata[0] !== 32'h01010101 || rdata[1] !== 32'h02020202) begin
      n_fail++; $display("FAIL rand_seed: got %h %h expected 01010101 02020202", rdata[0], rdata[1]);
    end
    cyc();
    n_cmp++;
    if (rdata[0] !== 32'h02020202 || rdata[1] !== 32'h04040404) begin
      n_fail++; $display("FAIL rand_step: got %h %h expected 02020202 04040404", rdata[0], rdata[1]);
    end
    rnd = 1'b0;
    #1;
    n_cmp++;
    if (rdata !== 64'h0) begin
      n_fail++; $display("FAIL rand_off: got %h expected 0", rdata);
    end
  endtask

  initial begin
    rst = 1'b1; rnd = 1'b0; en = 1'b1; stl = 1'b0;
    s1_req = 1'b0; s1_stl = 1'b0; s5_req = 1'b0; s5_stl = 1'b0;
    idle_all();
    test_reset();
    test_stall();
    test_write_read();
    test_byte_enable();
    test_wrap();
    test_conflict();
    test_back_to_back();
    test_enable_counters();
    test_reset_midop();
    test_randomize();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
